instr_fetch: RTL and testbench

Instruction-fetch stage of the single-cycle MIPS datapath, directly upstream of the control decoder. Holds the PC, fetches each 32-bit word from instruction memory over a req/ready handshake, and presents the word with its `opcode`/`funct` fields to the decoder. It then computes the next PC from the sequential, branch or jump outcome reported back by the datapath. It also counts retired instructions.

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/npc_calc.sv | 29 ++
 rtl/instr_fetch.sv | 95 +++++++++
 tb/tb_instr_fetch.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, reset PC
// and MIPS instruction field positions.
package instr_fetch_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned JIDX_MSB   = 25;
  localparam int unsigned JIDX_LSB   = 0;
  localparam int unsigned JIDX_W     = JIDX_MSB - JIDX_LSB + 1;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
module npc_calc
  import instr_fetch_pkg::*;
(
  input  logic [31:0]       pc_plus4,
  input  logic              branch_taken,
  input  logic [15:0]       branch_off,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_idx,
  output logic [31:0]       npc
);

  logic [31:0] br_target;
  logic [31:0] j_target;

  // Branch offset is in words; shift keeps the result word-aligned.
  assign br_target = pc_plus4 + {{14{branch_off[15]}}, branch_off, 2'b00};
  assign j_target  = {pc_plus4[31:28], jump_idx, 2'b00};

  always_comb begin
    npc = pc_plus4;
    if (jump) begin
      npc = j_target;
    end else if (branch_taken) begin
      npc = br_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ready handshake,
// presents the word to the decoder and retires it into the next PC.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_off,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_idx,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       icount
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] icount_q, icount_d;
  logic [31:0] npc;

  assign pc_plus4 = pc_q + 32'd4;

  npc_calc u_npc_calc (
    .pc_plus4     (pc_plus4),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump         (jump),
    .jump_idx     (jump_idx),
    .npc          (npc)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    icount_d = icount_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Control-flow inputs only matter on the retiring cycle.
        if (!stall) begin
          pc_d     = npc;
          icount_d = icount_q + 32'd1;
          state_d  = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC_ALIGNED;
      instr_q  <= 32'd0;
      icount_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      icount_q <= icount_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == ISSUE);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign icount      = icount_q;
  assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; outputs sampled on falling edges.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_off;
  logic        jump;
  logic [25:0] jump_idx;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] icount;

  int ncmp = 0;
  int nerr = 0;

  instr_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump         (jump),
    .jump_idx     (jump_idx),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .opcode       (opcode),
    .funct        (funct),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .icount       (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive-only: from a FETCH cycle, return a word with no wait; lands in ISSUE.
  task automatic give_word(input logic [31:0] word);
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  // Drive-only: retire the presented word with the given control-flow outcome.
  task automatic retire(input logic j, input logic [25:0] ji, input logic b,
                        input logic [15:0] bo);
    stall = 1'b0; jump = j; jump_idx = ji; branch_taken = b; branch_off = bo;
    tick();
    jump = 1'b0; jump_idx = '0; branch_taken = 1'b0; branch_off = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    ncmp++; if (pc !== 32'h3000) begin nerr++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h3000); end
    ncmp++; if (instr !== 32'h0) begin nerr++; $display("FAIL rst_instr got=%h exp=0", instr); end
    ncmp++; if (opcode !== 6'h0) begin nerr++; $display("FAIL rst_opcode got=%h exp=0", opcode); end
    ncmp++; if (funct !== 6'h0) begin nerr++; $display("FAIL rst_funct got=%h exp=0", funct); end
    ncmp++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    ncmp++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    ncmp++; if (icount !== 32'h0) begin nerr++; $display("FAIL rst_icount got=%h exp=0", icount); end
    rst_n = 1'b1;
    tick();
    ncmp++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL first_req got=%b exp=1", imem_req); end
    ncmp++; if (imem_addr !== 32'h3000) begin nerr++; $display("FAIL first_addr got=%h exp=%h", imem_addr, 32'h3000); end
  endtask

  task automatic test_zero_wait();
    give_word(32'h0000_0020);
    ncmp++; if (instr_valid !== 1'b1) begin nerr++; $display("FAIL zw_valid got=%b exp=1", instr_valid); end
    ncmp++; if (opcode !== 6'h00) begin nerr++; $display("FAIL zw_opcode got=%h exp=00", opcode); end
    ncmp++; if (funct !== 6'h20) begin nerr++; $display("FAIL zw_funct got=%h exp=20", funct); end
    ncmp++; if (pc !== 32'h3000) begin nerr++; $display("FAIL zw_pc got=%h exp=3000", pc); end
    ncmp++; if (pc_plus4 !== 32'h3004) begin nerr++; $display("FAIL zw_pc4 got=%h exp=3004", pc_plus4); end
    ncmp++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL zw_req_issue got=%b exp=0", imem_req); end
    retire(1'b0, '0, 1'b0, '0);
    ncmp++; if (imem_addr !== 32'h3004) begin nerr++; $display("FAIL zw_next_addr got=%h exp=3004", imem_addr); end
    ncmp++; if (icount !== 32'd1) begin nerr++; $display("FAIL zw_icount got=%0d exp=1", icount); end
    ncmp++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL zw_valid_clr got=%b exp=0", instr_valid); end
  endtask

  task automatic test_wait_states();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ncmp++; if (imem_addr !== 32'h3004) begin nerr++; $display("FAIL ws_addr[%0d] got=%h exp=3004", i, imem_addr); end
      ncmp++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL ws_valid[%0d] got=%b exp=0", i, instr_valid); end
      tick();
    end
    ncmp++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL ws_req got=%b exp=1", imem_req); end
    give_word(32'h8C22_0004);
    ncmp++; if (instr_valid !== 1'b1) begin nerr++; $display("FAIL ws_valid_late got=%b exp=1", instr_valid); end
    ncmp++; if (opcode !== 6'h23) begin nerr++; $display("FAIL ws_opcode got=%h exp=23", opcode); end
    ncmp++; if (funct !== 6'h04) begin nerr++; $display("FAIL ws_funct got=%h exp=04", funct); end
    retire(1'b0, '0, 1'b0, '0);
    ncmp++; if (imem_addr !== 32'h3008) begin nerr++; $display("FAIL ws_next_addr got=%h exp=3008", imem_addr); end
    ncmp++; if (icount !== 32'd2) begin nerr++; $display("FAIL ws_icount got=%0d exp=2", icount); end
  endtask

  task automatic test_branch_jump();
    give_word(32'h0); retire(1'b0, '0, 1'b0, '0);
    give_word(32'h0); retire(1'b0, '0, 1'b0, '0);
    give_word(32'h1000_FFFC);
    ncmp++; if (pc !== 32'h3010) begin nerr++; $display("FAIL br_pc got=%h exp=3010", pc); end
    retire(1'b0, '0, 1'b1, 16'hFFFC);
    ncmp++; if (imem_addr !== 32'h3004) begin nerr++; $display("FAIL br_target got=%h exp=3004", imem_addr); end
    ncmp++; if (icount !== 32'd5) begin nerr++; $display("FAIL br_icount got=%0d exp=5", icount); end
    give_word(32'h0800_0C10);
    retire(1'b1, 26'h0000C10, 1'b0, '0);
    ncmp++; if (imem_addr !== 32'h3040) begin nerr++; $display("FAIL j_target got=%h exp=3040", imem_addr); end
  endtask

  task automatic test_stall();
    give_word(32'h0000_0022);
    stall = 1'b1;
    jump_idx = 26'h0000100;
    for (int i = 0; i < 5; i++) begin
      jump = (i % 2 == 0);
      branch_taken = 1'b1; branch_off = 16'h0040;
      imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      tick();
      ncmp++; if (pc !== 32'h3040) begin nerr++; $display("FAIL st_pc[%0d] got=%h exp=3040", i, pc); end
      ncmp++; if (instr !== 32'h22) begin nerr++; $display("FAIL st_instr[%0d] got=%h exp=22", i, instr); end
      ncmp++; if (icount !== 32'd6) begin nerr++; $display("FAIL st_icount[%0d] got=%0d exp=6", i, icount); end
      ncmp++; if (instr_valid !== 1'b1) begin nerr++; $display("FAIL st_valid[%0d] got=%b exp=1", i, instr_valid); end
    end
    imem_ready = 1'b0;
    retire(1'b0, 26'h0000100, 1'b0, '0);
    ncmp++; if (imem_addr !== 32'h3044) begin nerr++; $display("FAIL st_next_addr got=%h exp=3044", imem_addr); end
    ncmp++; if (icount !== 32'd7) begin nerr++; $display("FAIL st_icount_ret got=%0d exp=7", icount); end
  endtask

  task automatic test_async_reset();
    imem_ready = 1'b0;
    tick();
    ncmp++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL ar_req_before got=%b exp=1", imem_req); end
    #2 rst_n = 1'b0;
    #1;
    ncmp++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL ar_req_drop got=%b exp=0", imem_req); end
    ncmp++; if (pc !== 32'h3000) begin nerr++; $display("FAIL ar_pc got=%h exp=3000", pc); end
    ncmp++; if (icount !== 32'd0) begin nerr++; $display("FAIL ar_icount got=%0d exp=0", icount); end
    tick();
    rst_n = 1'b1;
    tick();
    ncmp++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL ar_restart_req got=%b exp=1", imem_req); end
    ncmp++; if (imem_addr !== 32'h3000) begin nerr++; $display("FAIL ar_restart_addr got=%h exp=3000", imem_addr); end
  endtask

  task automatic test_priority_wrap();
    give_word(32'h0);
    retire(1'b1, 26'h0000800, 1'b1, 16'h0010);
    ncmp++; if (imem_addr !== 32'h2000) begin nerr++; $display("FAIL prio_target got=%h exp=2000", imem_addr); end
    ncmp++; if (icount !== 32'd1) begin nerr++; $display("FAIL prio_icount got=%0d exp=1", icount); end
    give_word(32'h0);
    retire(1'b0, '0, 1'b1, 16'hF7FE);
    ncmp++; if (imem_addr !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_br got=%h exp=fffffffc", imem_addr); end
    ncmp++; if (pc_plus4 !== 32'h0) begin nerr++; $display("FAIL wrap_pc4 got=%h exp=0", pc_plus4); end
    give_word(32'h0);
    retire(1'b0, '0, 1'b0, '0);
    ncmp++; if (imem_addr !== 32'h0) begin nerr++; $display("FAIL wrap_seq got=%h exp=0", imem_addr); end
    ncmp++; if (icount !== 32'd3) begin nerr++; $display("FAIL wrap_icount got=%0d exp=3", icount); end
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_off = '0; jump = 1'b0; jump_idx = '0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch_jump();
    test_stall();
    test_async_reset();
    test_priority_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
